// File: rtl/bp_common_pkg.sv
// rtl/bp_common_pkg.sv - shared TLB map record types, state encoding and entry-width macro
`define BP_TLB_ENTRY_WIDTH_MP(ptag_width) ((ptag_width) + 3)

package bp_common_pkg;

  localparam int vtag_width_gp = 27;
  localparam int ptag_width_gp = 28;

  typedef enum logic [1:0] {
    e_tlb_rec_fill  = 2'd0,
    e_tlb_rec_clear = 2'd1,
    e_tlb_rec_end   = 2'd2
  } bp_tlb_rec_op_e;

  // op is kept as raw bits so the reserved encoding 3 can still be carried
  typedef struct packed {
    logic [1:0]               op;
    logic                     tlb_sel;
    logic [vtag_width_gp-1:0] vtag;
    logic [ptag_width_gp-1:0] ptag;
    logic [2:0]               perm;
  } bp_tlb_rec_s;

  typedef enum logic [1:0] {
    e_seq_idle       = 2'd0,
    e_seq_issue      = 2'd1,
    e_seq_clear_wait = 2'd2,
    e_seq_done       = 2'd3
  } bp_tlb_seq_state_e;

  // perm is {x,w,r}; w without r is reserved, and an all-zero perm maps nothing
  function automatic logic perm_is_reserved(input logic [2:0] perm);
    return (perm == 3'b000) || (perm[1] && !perm[0]);
  endfunction

endpackage

// File: rtl/bp_tlb_fill_seq_sat_counter.sv
// rtl/bp_tlb_fill_seq_sat_counter.sv - saturating up-counter for per-TLB fill counts
module bp_tlb_fill_seq_sat_counter #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q;
  logic [width_p-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (up_i && (count_q != {width_p{1'b1}})) begin
      count_d = count_q + width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bp_tlb_fill_sequencer.sv
// rtl/bp_tlb_fill_sequencer.sv - issues VM map records as ITLB/DTLB fill and clear strobes
// Optional: BP_TLB_FILL_SEQ_PERM_CHECK_EN drops fills carrying a reserved permission encoding.
module bp_tlb_fill_sequencer
  import bp_common_pkg::*;
#(
  parameter int vtag_width_p   = 27,
  parameter int ptag_width_p   = 28,
  parameter int clear_cycles_p = 4,
  parameter int count_width_p  = 16
) (
  input  logic                                       clk_i,
  input  logic                                       reset_n_i,

  input  logic                                       rec_v_i,
  output logic                                       rec_ready_o,
  input  logic [1:0]                                 rec_op_i,
  input  logic                                       rec_tlb_sel_i,
  input  logic [vtag_width_p-1:0]                    rec_vtag_i,
  input  logic [ptag_width_p-1:0]                    rec_ptag_i,
  input  logic [2:0]                                 rec_perm_i,

  input  logic                                       itlb_ready_i,
  output logic                                       itlb_fill_v_o,
  output logic                                       itlb_clear_o,
  output logic [vtag_width_p-1:0]                    itlb_vtag_o,
  output logic [`BP_TLB_ENTRY_WIDTH_MP(ptag_width_p)-1:0] itlb_entry_o,

  input  logic                                       dtlb_ready_i,
  output logic                                       dtlb_fill_v_o,
  output logic                                       dtlb_clear_o,
  output logic [vtag_width_p-1:0]                    dtlb_vtag_o,
  output logic [`BP_TLB_ENTRY_WIDTH_MP(ptag_width_p)-1:0] dtlb_entry_o,

  output logic [count_width_p-1:0]                   itlb_fill_count_o,
  output logic [count_width_p-1:0]                   dtlb_fill_count_o,
  output logic                                       done_o,
  output logic                                       error_o
);

  localparam int entry_width_lp = `BP_TLB_ENTRY_WIDTH_MP(ptag_width_p);
  localparam int wait_width_lp  = (clear_cycles_p > 1) ? $clog2(clear_cycles_p) : 1;

  bp_tlb_seq_state_e         state_q;
  logic [1:0]                op_q;
  logic                      sel_q;
  logic [vtag_width_p-1:0]   vtag_q;
  logic [ptag_width_p-1:0]   ptag_q;
  logic [2:0]                perm_q;
  logic [wait_width_lp-1:0]  wait_q;
  logic                      error_q;

  logic                      perm_bad;
  logic                      issue;
  logic                      target_ready;
  logic                      itlb_issue;
  logic                      dtlb_issue;
  logic [entry_width_lp-1:0] entry;

`ifdef BP_TLB_FILL_SEQ_PERM_CHECK_EN
  assign perm_bad = perm_is_reserved(rec_perm_i);
`else
  assign perm_bad = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_seq_idle;
      op_q    <= 2'b00;
      sel_q   <= 1'b0;
      vtag_q  <= '0;
      ptag_q  <= '0;
      perm_q  <= 3'b000;
      wait_q  <= '0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        e_seq_idle: begin
          if (rec_v_i) begin
            if ((rec_op_i == e_tlb_rec_fill) && perm_bad) begin
              error_q <= 1'b1;
            end else if ((rec_op_i == e_tlb_rec_fill) || (rec_op_i == e_tlb_rec_clear)) begin
              op_q    <= rec_op_i;
              sel_q   <= rec_tlb_sel_i;
              vtag_q  <= rec_vtag_i;
              ptag_q  <= rec_ptag_i;
              perm_q  <= rec_perm_i;
              state_q <= e_seq_issue;
            end else if (rec_op_i == e_tlb_rec_end) begin
              state_q <= e_seq_done;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        e_seq_issue: begin
          if (target_ready) begin
            if (op_q == e_tlb_rec_clear) begin
              wait_q  <= wait_width_lp'(clear_cycles_p - 1);
              state_q <= e_seq_clear_wait;
            end else begin
              state_q <= e_seq_idle;
            end
          end
        end
        // counter value 0 is the last wait cycle, giving clear_cycles_p cycles in total
        e_seq_clear_wait: begin
          if (wait_q == '0) begin
            state_q <= e_seq_idle;
          end else begin
            wait_q <= wait_q - wait_width_lp'(1);
          end
        end
        e_seq_done: begin
          state_q <= e_seq_done;
        end
        default: begin
          state_q <= e_seq_idle;
        end
      endcase
    end
  end

  assign issue        = (state_q == e_seq_issue);
  assign target_ready = sel_q ? dtlb_ready_i : itlb_ready_i;
  assign itlb_issue   = issue && !sel_q;
  assign dtlb_issue   = issue && sel_q;
  assign entry        = {ptag_q, perm_q};

  assign itlb_fill_v_o = itlb_issue && itlb_ready_i && (op_q == e_tlb_rec_fill);
  assign itlb_clear_o  = itlb_issue && itlb_ready_i && (op_q == e_tlb_rec_clear);
  assign itlb_vtag_o   = itlb_issue ? vtag_q : '0;
  assign itlb_entry_o  = itlb_issue ? entry : '0;

  assign dtlb_fill_v_o = dtlb_issue && dtlb_ready_i && (op_q == e_tlb_rec_fill);
  assign dtlb_clear_o  = dtlb_issue && dtlb_ready_i && (op_q == e_tlb_rec_clear);
  assign dtlb_vtag_o   = dtlb_issue ? vtag_q : '0;
  assign dtlb_entry_o  = dtlb_issue ? entry : '0;

  assign rec_ready_o = (state_q == e_seq_idle);
  assign done_o      = (state_q == e_seq_done);
  assign error_o     = error_q;

  bp_tlb_fill_seq_sat_counter #(
    .width_p (count_width_p)
  ) u_itlb_count (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .up_i      (itlb_fill_v_o),
    .count_o   (itlb_fill_count_o)
  );

  bp_tlb_fill_seq_sat_counter #(
    .width_p (count_width_p)
  ) u_dtlb_count (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .up_i      (dtlb_fill_v_o),
    .count_o   (dtlb_fill_count_o)
  );

endmodule
